rename_stage: RTL and testbench

RENAME_STAGE -- requirements
Module: rename_stage

---
 rtl/rename_stage.sv | 239 +++++++++++++++++++++++
 tb/tb_rename_stage.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_stage.sv
// rename_stage: dual-issue register rename stage.
// Maps architectural sources to ready values or producer tags using a RAT
// (busy bit + tag per register) and a 32x32 register file, allocates tags
// to destination writers sequentially, and snoops four CDB ports (alu1,
// alu2, ld1, ld2) for wakeup and writeback. The renamed bundle is registered.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   stall_in                 downstream full: hold the output bundle
//   valid1/2, rs*/rt*/rd*/wr* decoded slot 1 / slot 2 instructions
//   alu*/ld*_wr/_res_tag/_res CDB broadcasts
//   out_valid*, ready_*, *_tag, val*_*, dest*, dest*_tag, write*  renamed bundle
//   stall_out                rename cannot accept (too many outstanding tags)
module rename_stage #(
    parameter int NTAGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        valid1,
    input  logic        valid2,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rt1,
    input  logic [4:0]  rd1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rt2,
    input  logic [4:0]  rd2,
    input  logic        wr1,
    input  logic        wr2,
    input  logic        alu1_wr,
    input  logic        alu2_wr,
    input  logic        ld1_wr,
    input  logic        ld2_wr,
    input  logic [4:0]  alu1_res_tag,
    input  logic [4:0]  alu2_res_tag,
    input  logic [4:0]  ld1_res_tag,
    input  logic [4:0]  ld2_res_tag,
    input  logic [31:0] alu1_res,
    input  logic [31:0] alu2_res,
    input  logic [31:0] ld1_res,
    input  logic [31:0] ld2_res,
    output logic        out_valid1,
    output logic        out_valid2,
    output logic        ready_rs1,
    output logic        ready_rt1,
    output logic        ready_rs2,
    output logic        ready_rt2,
    output logic [4:0]  rs1_tag,
    output logic [4:0]  rt1_tag,
    output logic [4:0]  rs2_tag,
    output logic [4:0]  rt2_tag,
    output logic [31:0] val1_1,
    output logic [31:0] val2_1,
    output logic [31:0] val1_2,
    output logic [31:0] val2_2,
    output logic [4:0]  dest1,
    output logic [4:0]  dest2,
    output logic [4:0]  dest1_tag,
    output logic [4:0]  dest2_tag,
    output logic        write1,
    output logic        write2,
    output logic        stall_out
);

    typedef struct packed {
        logic        hit;
        logic [31:0] val;
    } cdb_hit_t;

    // A ready operand carries tag 0; a waiting operand carries value 0.
    typedef struct packed {
        logic        ready;
        logic [4:0]  tag;
        logic [31:0] val;
    } opnd_t;

    typedef struct packed {
        logic        valid;
        opnd_t       rs;
        opnd_t       rt;
        logic [4:0]  dest;
        logic [4:0]  dest_tag;
        logic        write;
    } slot_t;

    logic [31:0] rat_busy_q, rat_busy_d;
    logic [4:0]  rat_tag_q [32];
    logic [4:0]  rat_tag_d [32];
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];
    logic [4:0]  next_tag_q, next_tag_d;
    logic [5:0]  outstanding_q, outstanding_d;
    slot_t       slot_q [2];
    slot_t       slot_d [2];

    logic        accept_s, alloc1_s, alloc2_s;
    logic [4:0]  tag1_s, tag2_s;
    logic [1:0]  n_alloc_s;
    logic [2:0]  n_cdb_s;
    opnd_t       op_rs1_s, op_rt1_s, op_rs2_s, op_rt2_s;
    cdb_hit_t    wb_s [32];

    // First CDB port carrying tag t, in priority alu1 > alu2 > ld1 > ld2.
    function automatic cdb_hit_t cdb_lookup(input logic [4:0] t);
        cdb_hit_t r;
        if (alu1_wr && (alu1_res_tag == t))     r = '{hit: 1'b1, val: alu1_res};
        else if (alu2_wr && (alu2_res_tag == t)) r = '{hit: 1'b1, val: alu2_res};
        else if (ld1_wr && (ld1_res_tag == t))   r = '{hit: 1'b1, val: ld1_res};
        else if (ld2_wr && (ld2_res_tag == t))   r = '{hit: 1'b1, val: ld2_res};
        else                                     r = '{hit: 1'b0, val: 32'h0};
        return r;
    endfunction

    // Source lookup: r0, then intra-bundle RAW, then RAT/register file with CDB bypass.
    function automatic opnd_t rename_src(input logic [4:0] s, input logic raw_hit,
                                         input logic [4:0] raw_tag);
        opnd_t    o;
        cdb_hit_t h;
        h = cdb_lookup(rat_tag_q[s]);
        if (s == 5'd0)           o = '{ready: 1'b1, tag: 5'd0, val: 32'h0};
        else if (raw_hit)        o = '{ready: 1'b0, tag: raw_tag, val: 32'h0};
        else if (!rat_busy_q[s]) o = '{ready: 1'b1, tag: 5'd0, val: rf_q[s]};
        else if (h.hit)          o = '{ready: 1'b1, tag: 5'd0, val: h.val};
        else                     o = '{ready: 1'b0, tag: rat_tag_q[s], val: 32'h0};
        return o;
    endfunction

    // Wake a registered operand that is still waiting on a broadcast tag.
    function automatic opnd_t snoop(input opnd_t o);
        opnd_t    r;
        cdb_hit_t h;
        h = cdb_lookup(o.tag);
        if (!o.ready && h.hit) r = '{ready: 1'b1, tag: 5'd0, val: h.val};
        else                   r = o;
        return r;
    endfunction

    assign stall_out = (outstanding_q > 6'(NTAGS - 3));

    // Accept decision, tag allocation and counter updates.
    always_comb begin
        accept_s      = (valid1 | valid2) & ~stall_in & ~stall_out;
        alloc1_s      = accept_s & valid1 & wr1 & (rd1 != 5'd0);
        alloc2_s      = accept_s & valid2 & wr2 & (rd2 != 5'd0);
        tag1_s        = next_tag_q;
        tag2_s        = next_tag_q + {4'd0, alloc1_s};
        n_alloc_s     = {1'b0, alloc1_s} + {1'b0, alloc2_s};
        n_cdb_s       = {2'b0, alu1_wr} + {2'b0, alu2_wr} + {2'b0, ld1_wr} + {2'b0, ld2_wr};
        next_tag_d    = next_tag_q + {3'd0, n_alloc_s};
        outstanding_d = outstanding_q + {4'd0, n_alloc_s} - {3'd0, n_cdb_s};
    end

    // Operand lookups for both slots; slot-2 sources see slot 1's new tag.
    always_comb begin
        op_rs1_s = rename_src(rs1, 1'b0, tag1_s);
        op_rt1_s = rename_src(rt1, 1'b0, tag1_s);
        op_rs2_s = rename_src(rs2, valid1 & wr1 & (rd1 == rs2), tag1_s);
        op_rt2_s = rename_src(rt2, valid1 & wr1 & (rd1 == rt2), tag1_s);
    end

    // RAT and register file: rename (slot 2 over slot 1) beats CDB writeback.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            wb_s[i] = cdb_lookup(rat_tag_q[i]);
            if (alloc2_s && (rd2 == 5'(i))) begin
                rat_busy_d[i] = 1'b1;
                rat_tag_d[i]  = tag2_s;
            end else if (alloc1_s && (rd1 == 5'(i))) begin
                rat_busy_d[i] = 1'b1;
                rat_tag_d[i]  = tag1_s;
            end else if (rat_busy_q[i] && wb_s[i].hit) begin
                rat_busy_d[i] = 1'b0;
                rat_tag_d[i]  = rat_tag_q[i];
            end else begin
                rat_busy_d[i] = rat_busy_q[i];
                rat_tag_d[i]  = rat_tag_q[i];
            end
            if (rat_busy_q[i] && wb_s[i].hit) rf_d[i] = wb_s[i].val;
            else                              rf_d[i] = rf_q[i];
        end
    end

    // Output bundle: load on accept, otherwise hold (valid only under stall_in) and snoop.
    always_comb begin
        if (accept_s) begin
            slot_d[0] = '{valid: valid1, rs: op_rs1_s, rt: op_rt1_s, dest: rd1,
                          dest_tag: alloc1_s ? tag1_s : 5'd0, write: wr1};
            slot_d[1] = '{valid: valid2, rs: op_rs2_s, rt: op_rt2_s, dest: rd2,
                          dest_tag: alloc2_s ? tag2_s : 5'd0, write: wr2};
        end else begin
            for (int k = 0; k < 2; k++) begin
                slot_d[k]       = slot_q[k];
                slot_d[k].rs    = snoop(slot_q[k].rs);
                slot_d[k].rt    = snoop(slot_q[k].rt);
                slot_d[k].valid = slot_q[k].valid & stall_in;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rat_busy_q    <= 32'd0;
            rat_tag_q     <= '{default: 5'd0};
            rf_q          <= '{default: 32'd0};
            next_tag_q    <= 5'd0;
            outstanding_q <= 6'd0;
            slot_q        <= '{default: '0};
        end else begin
            rat_busy_q    <= rat_busy_d;
            rat_tag_q     <= rat_tag_d;
            rf_q          <= rf_d;
            next_tag_q    <= next_tag_d;
            outstanding_q <= outstanding_d;
            slot_q        <= slot_d;
        end
    end

    assign out_valid1 = slot_q[0].valid;
    assign out_valid2 = slot_q[1].valid;
    assign ready_rs1  = slot_q[0].rs.ready;
    assign ready_rt1  = slot_q[0].rt.ready;
    assign ready_rs2  = slot_q[1].rs.ready;
    assign ready_rt2  = slot_q[1].rt.ready;
    assign rs1_tag    = slot_q[0].rs.tag;
    assign rt1_tag    = slot_q[0].rt.tag;
    assign rs2_tag    = slot_q[1].rs.tag;
    assign rt2_tag    = slot_q[1].rt.tag;
    assign val1_1     = slot_q[0].rs.val;
    assign val2_1     = slot_q[0].rt.val;
    assign val1_2     = slot_q[1].rs.val;
    assign val2_2     = slot_q[1].rt.val;
    assign dest1      = slot_q[0].dest;
    assign dest2      = slot_q[1].dest;
    assign dest1_tag  = slot_q[0].dest_tag;
    assign dest2_tag  = slot_q[1].dest_tag;
    assign write1     = slot_q[0].write;
    assign write2     = slot_q[1].write;

endmodule

// File: tb/tb_rename_stage.sv
module tb_rename_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_in, valid1, valid2, wr1, wr2;
    logic [4:0]  rs1, rt1, rd1, rs2, rt2, rd2;
    logic        alu1_wr, alu2_wr, ld1_wr, ld2_wr;
    logic [4:0]  alu1_res_tag, alu2_res_tag, ld1_res_tag, ld2_res_tag;
    logic [31:0] alu1_res, alu2_res, ld1_res, ld2_res;
    logic        out_valid1, out_valid2, ready_rs1, ready_rt1, ready_rs2, ready_rt2;
    logic [4:0]  rs1_tag, rt1_tag, rs2_tag, rt2_tag;
    logic [31:0] val1_1, val2_1, val1_2, val2_2;
    logic [4:0]  dest1, dest2, dest1_tag, dest2_tag;
    logic        write1, write2, stall_out;

    int checks = 0;
    int errors = 0;

    rename_stage #(.NTAGS(32)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in),
        .valid1(valid1), .valid2(valid2),
        .rs1(rs1), .rt1(rt1), .rd1(rd1), .rs2(rs2), .rt2(rt2), .rd2(rd2),
        .wr1(wr1), .wr2(wr2),
        .alu1_wr(alu1_wr), .alu2_wr(alu2_wr), .ld1_wr(ld1_wr), .ld2_wr(ld2_wr),
        .alu1_res_tag(alu1_res_tag), .alu2_res_tag(alu2_res_tag),
        .ld1_res_tag(ld1_res_tag), .ld2_res_tag(ld2_res_tag),
        .alu1_res(alu1_res), .alu2_res(alu2_res), .ld1_res(ld1_res), .ld2_res(ld2_res),
        .out_valid1(out_valid1), .out_valid2(out_valid2),
        .ready_rs1(ready_rs1), .ready_rt1(ready_rt1), .ready_rs2(ready_rs2), .ready_rt2(ready_rt2),
        .rs1_tag(rs1_tag), .rt1_tag(rt1_tag), .rs2_tag(rs2_tag), .rt2_tag(rt2_tag),
        .val1_1(val1_1), .val2_1(val2_1), .val1_2(val1_2), .val2_2(val2_2),
        .dest1(dest1), .dest2(dest2), .dest1_tag(dest1_tag), .dest2_tag(dest2_tag),
        .write1(write1), .write2(write2), .stall_out(stall_out)
    );

    always #5 clk = ~clk;

    // Reference model: architectural view of rename state and the expected bundle.
    bit          m_busy [32];
    int          m_tag  [32];
    logic [31:0] m_rf   [32];
    int          m_next, m_outst;
    bit          e_valid [2];
    bit          e_rdy   [4];   // rs1, rt1, rs2, rt2
    int          e_tag   [4];
    logic [31:0] e_val   [4];
    int          e_dest  [2];
    int          e_dtag  [2];
    bit          e_write [2];

    function automatic bit cdb_find(input int tag, output logic [31:0] v);
        bit          w [4];
        int          t [4];
        logic [31:0] d [4];
        bit          found;
        w = '{alu1_wr, alu2_wr, ld1_wr, ld2_wr};
        t = '{int'(alu1_res_tag), int'(alu2_res_tag), int'(ld1_res_tag), int'(ld2_res_tag)};
        d = '{alu1_res, alu2_res, ld1_res, ld2_res};
        found = 1'b0;
        v = 32'h0;
        for (int p = 0; p < 4; p++) begin
            if (!found && w[p] && t[p] == tag) begin
                found = 1'b1;
                v = d[p];
            end
        end
        return found;
    endfunction

    function automatic void src(input int r, input bit slot2, input int t1,
                                output bit rdy, output int tg, output logic [31:0] v);
        logic [31:0] cv;
        rdy = 1'b1; tg = 0; v = 32'h0;
        if (r == 0) begin
            rdy = 1'b1;
        end else if (slot2 && valid1 && wr1 && int'(rd1) == r) begin
            rdy = 1'b0; tg = t1;
        end else if (!m_busy[r]) begin
            v = m_rf[r];
        end else if (cdb_find(m_tag[r], cv)) begin
            v = cv;
        end else begin
            rdy = 1'b0; tg = m_tag[r];
        end
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin m_busy[r] = 0; m_tag[r] = 0; m_rf[r] = 0; end
        for (int k = 0; k < 4; k++) begin e_rdy[k] = 0; e_tag[k] = 0; e_val[k] = 0; end
        for (int k = 0; k < 2; k++) begin e_valid[k] = 0; e_dest[k] = 0; e_dtag[k] = 0; e_write[k] = 0; end
        m_next = 0; m_outst = 0;
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        bit acc, a1, a2;
        int t1, t2, ncdb;
        logic [31:0] v;
        acc = (valid1 || valid2) && !stall_in && !(m_outst > 32 - 3);
        a1  = acc && valid1 && wr1 && rd1 != 0;
        a2  = acc && valid2 && wr2 && rd2 != 0;
        t1  = m_next;
        t2  = (m_next + int'(a1)) % 32;
        if (acc) begin
            src(int'(rs1), 0, t1, e_rdy[0], e_tag[0], e_val[0]);
            src(int'(rt1), 0, t1, e_rdy[1], e_tag[1], e_val[1]);
            src(int'(rs2), 1, t1, e_rdy[2], e_tag[2], e_val[2]);
            src(int'(rt2), 1, t1, e_rdy[3], e_tag[3], e_val[3]);
            e_valid[0] = valid1; e_valid[1] = valid2;
            e_dest[0] = int'(rd1); e_dest[1] = int'(rd2);
            e_dtag[0] = a1 ? t1 : 0; e_dtag[1] = a2 ? t2 : 0;
            e_write[0] = wr1; e_write[1] = wr2;
        end else begin
            for (int k = 0; k < 4; k++)
                if (!e_rdy[k] && cdb_find(e_tag[k], v)) begin
                    e_rdy[k] = 1; e_tag[k] = 0; e_val[k] = v;
                end
            if (!stall_in) begin e_valid[0] = 0; e_valid[1] = 0; end
        end
        for (int r = 0; r < 32; r++)
            if (m_busy[r] && cdb_find(m_tag[r], v)) begin m_busy[r] = 0; m_rf[r] = v; end
        if (a1) begin m_busy[rd1] = 1; m_tag[rd1] = t1; end
        if (a2) begin m_busy[rd2] = 1; m_tag[rd2] = t2; end
        ncdb    = int'(alu1_wr) + int'(alu2_wr) + int'(ld1_wr) + int'(ld2_wr);
        m_next  = (m_next + int'(a1) + int'(a2)) % 32;
        m_outst = (m_outst + int'(a1) + int'(a2) - ncdb + 64) % 64;
    endtask

    function automatic logic [175:0] exp_vec();
        return {e_valid[0], e_valid[1], e_rdy[0], e_rdy[1], e_rdy[2], e_rdy[3],
                5'(e_tag[0]), 5'(e_tag[1]), 5'(e_tag[2]), 5'(e_tag[3]),
                e_val[0], e_val[1], e_val[2], e_val[3],
                5'(e_dest[0]), 5'(e_dest[1]), 5'(e_dtag[0]), 5'(e_dtag[1]),
                e_write[0], e_write[1]};
    endfunction

    function automatic logic [175:0] dut_vec();
        return {out_valid1, out_valid2, ready_rs1, ready_rt1, ready_rs2, ready_rt2,
                rs1_tag, rt1_tag, rs2_tag, rt2_tag, val1_1, val2_1, val1_2, val2_2,
                dest1, dest2, dest1_tag, dest2_tag, write1, write2};
    endfunction

    task automatic clear_inputs();
        stall_in = 0; valid1 = 0; valid2 = 0; wr1 = 0; wr2 = 0;
        rs1 = 0; rt1 = 0; rd1 = 0; rs2 = 0; rt2 = 0; rd2 = 0;
        alu1_wr = 0; alu2_wr = 0; ld1_wr = 0; ld2_wr = 0;
        alu1_res_tag = 0; alu2_res_tag = 0; ld1_res_tag = 0; ld2_res_tag = 0;
        alu1_res = 0; alu2_res = 0; ld1_res = 0; ld2_res = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; clear_inputs(); model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== 176'd0 || stall_out !== 1'b0) begin
            errors++; $display("FAIL reset_state got %h stall %b want 0", dut_vec(), stall_out);
        end
        rst = 0;
    endtask

    task automatic test_single_add();
        clear_inputs(); valid1 = 1; rs1 = 1; rt1 = 2; rd1 = 3; wr1 = 1;
        tick();
        checks++;
        if ({out_valid1, ready_rs1, ready_rt1, val1_1, val2_1, dest1_tag} !== {3'b111, 64'd0, 5'd0}) begin
            errors++; $display("FAIL single_add got v%b r%b%b %h %h t%0d want v1 r11 0 0 t0",
                               out_valid1, ready_rs1, ready_rt1, val1_1, val2_1, dest1_tag);
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL single_add_model got %h want %h", dut_vec(), exp_vec()); end
        clear_inputs(); tick();
        checks++;
        if (out_valid1 !== 1'b0) begin errors++; $display("FAIL idle_clears_valid got %b want 0", out_valid1); end
    endtask

    task automatic test_intra_raw();
        clear_inputs();
        valid1 = 1; rs1 = 3; rt1 = 3; rd1 = 4; wr1 = 1;
        valid2 = 1; rs2 = 4; rt2 = 1; rd2 = 5; wr2 = 1;
        tick();
        checks++;
        if ({ready_rs1, rs1_tag, ready_rs2, rs2_tag, ready_rt2, dest1_tag, dest2_tag} !==
            {1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 5'd1, 5'd2}) begin
            errors++; $display("FAIL intra_raw got rs1 %b/%0d rs2 %b/%0d rt2 %b dt %0d %0d want 0/0 0/1 1 1 2",
                               ready_rs1, rs1_tag, ready_rs2, rs2_tag, ready_rt2, dest1_tag, dest2_tag);
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL intra_raw_model got %h want %h", dut_vec(), exp_vec()); end
    endtask

    task automatic test_cdb_bypass();
        clear_inputs(); valid1 = 1; rs1 = 3; rt1 = 0; rd1 = 6; wr1 = 0;
        alu1_wr = 1; alu1_res_tag = 0; alu1_res = 32'h55;
        tick();
        checks++;
        if ({ready_rs1, val1_1, ready_rt1, val2_1} !== {1'b1, 32'h55, 1'b1, 32'h0}) begin
            errors++; $display("FAIL cdb_bypass got %b %h %b %h want 1 55 1 0", ready_rs1, val1_1, ready_rt1, val2_1);
        end
        clear_inputs(); valid1 = 1; rs1 = 3; rt1 = 3;
        tick();
        checks++;
        if ({ready_rs1, val1_1, ready_rt1, val2_1} !== {1'b1, 32'h55, 1'b1, 32'h55}) begin
            errors++; $display("FAIL cdb_writeback got %b %h %b %h want 1 55 1 55", ready_rs1, val1_1, ready_rt1, val2_1);
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL cdb_model got %h want %h", dut_vec(), exp_vec()); end
    endtask

    task automatic test_waw();
        clear_inputs(); valid1 = 1; rd1 = 8; wr1 = 1; valid2 = 1; rd2 = 8; wr2 = 1;
        tick();
        checks++;
        if ({dest1_tag, dest2_tag} !== {5'd3, 5'd4}) begin
            errors++; $display("FAIL waw_alloc got %0d %0d want 3 4", dest1_tag, dest2_tag);
        end
        clear_inputs(); valid1 = 1; rs1 = 8;
        tick();
        checks++;
        if ({ready_rs1, rs1_tag} !== {1'b0, 5'd4}) begin
            errors++; $display("FAIL waw_rat got %b/%0d want 0/4", ready_rs1, rs1_tag);
        end
    endtask

    task automatic test_r0();
        clear_inputs(); valid1 = 1; rs1 = 0; rt1 = 0; rd1 = 0; wr1 = 1;
        tick();
        checks++;
        if ({ready_rs1, ready_rt1, val1_1, val2_1, dest1_tag} !== {2'b11, 64'd0, 5'd0}) begin
            errors++; $display("FAIL r0_rename got %b%b %h %h %0d want 11 0 0 0", ready_rs1, ready_rt1, val1_1, val2_1, dest1_tag);
        end
        clear_inputs(); valid1 = 1; rd1 = 9; wr1 = 1;
        tick();
        checks++;
        if (dest1_tag !== 5'd5) begin errors++; $display("FAIL r0_no_alloc got %0d want 5", dest1_tag); end
    endtask

    task automatic test_stall_in_snoop();
        int guard = 0;
        while (m_next != 7 && guard < 40) begin
            clear_inputs(); valid1 = 1; rd1 = 10; wr1 = 1; tick(); guard++;
        end
        clear_inputs(); valid1 = 1; rd1 = 12; wr1 = 1; tick();
        clear_inputs(); valid1 = 1; rs1 = 12;
        tick();
        checks++;
        if ({ready_rs1, rs1_tag} !== {1'b0, 5'd7}) begin errors++; $display("FAIL hold_setup got %b/%0d want 0/7", ready_rs1, rs1_tag); end
        clear_inputs(); stall_in = 1; valid1 = 1; rs1 = 1;
        ld2_wr = 1; ld2_res_tag = 7; ld2_res = 32'hABCD;
        tick();
        checks++;
        if ({out_valid1, ready_rs1, val1_1} !== {2'b11, 32'hABCD}) begin
            errors++; $display("FAIL hold_snoop got v%b r%b %h want v1 r1 abcd", out_valid1, ready_rs1, val1_1);
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL hold_model got %h want %h", dut_vec(), exp_vec()); end
        clear_inputs(); tick();
        checks++;
        if (out_valid1 !== 1'b0) begin errors++; $display("FAIL release_clears got %b want 0", out_valid1); end
    endtask

    task automatic drain();
        int guard = 0;
        while (m_outst > 0 && guard < 100) begin
            clear_inputs(); alu1_wr = 1; alu1_res_tag = 5'($urandom); alu1_res = $urandom;
            tick(); guard++;
            checks++;
            if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL drain_model got %h want %h", dut_vec(), exp_vec()); end
        end
    endtask

    task automatic test_stall_out();
        int accepted = 0;
        int prev = -1;
        bit saw_wrap = 0;
        drain();
        for (int n = 0; n < 40 && !stall_out; n++) begin
            clear_inputs(); valid1 = 1; wr1 = 1; rd1 = 5'(13 + n % 15); rs1 = 5'(12 + n % 15);
            tick();
            if (out_valid1) accepted++;
            if (prev == 31 && out_valid1 && dest1_tag == 5'd0) saw_wrap = 1;
            prev = int'(dest1_tag);
            checks++;
            if (dut_vec() !== exp_vec() || stall_out !== (m_outst > 29)) begin
                errors++; $display("FAIL fill_model n %0d got %h s%b want %h", n, dut_vec(), stall_out, exp_vec());
            end
        end
        checks++;
        if (stall_out !== 1'b1 || accepted != 30) begin
            errors++; $display("FAIL stall_out_rise got stall %b after %0d want 1 after 30", stall_out, accepted);
        end
        checks++;
        if (saw_wrap !== 1'b1) begin errors++; $display("FAIL tag_wrap got %b want 1", saw_wrap); end
        tick();
        checks++;
        if ({out_valid1, stall_out} !== 2'b01) begin errors++; $display("FAIL stall_blocks got v%b s%b want v0 s1", out_valid1, stall_out); end
        clear_inputs(); alu2_wr = 1; alu2_res_tag = 5'd5; alu2_res = 32'h1;
        tick();
        checks++;
        if (stall_out !== 1'b0) begin errors++; $display("FAIL stall_out_drop got %b want 0", stall_out); end
    endtask

    task automatic test_random();
        int cnt, r;
        drain();
        for (int i = 0; i < 400; i++) begin
            clear_inputs();
            valid1 = ($urandom % 4) != 0; valid2 = ($urandom % 4) != 0;
            rs1 = 5'($urandom); rt1 = 5'($urandom); rd1 = 5'($urandom % 12);
            rs2 = 5'($urandom % 12); rt2 = 5'($urandom); rd2 = 5'($urandom % 12);
            wr1 = $urandom % 2; wr2 = $urandom % 2;
            stall_in = ($urandom % 4) == 0;
            cnt = 0;
            if ($urandom % 3 == 0 && cnt < m_outst) begin
                r = $urandom % 32; alu1_wr = 1; alu1_res = $urandom; cnt++;
                alu1_res_tag = 5'(m_busy[r] ? m_tag[r] : $urandom);
            end
            if ($urandom % 3 == 0 && cnt < m_outst) begin
                r = $urandom % 32; alu2_wr = 1; alu2_res = $urandom; cnt++;
                alu2_res_tag = ($urandom % 4 == 0) ? alu1_res_tag : 5'(m_tag[r]);
            end
            if ($urandom % 3 == 0 && cnt < m_outst) begin
                r = $urandom % 32; ld1_wr = 1; ld1_res = $urandom; cnt++;
                ld1_res_tag = 5'(m_tag[r]);
            end
            if ($urandom % 3 == 0 && cnt < m_outst) begin
                r = $urandom % 32; ld2_wr = 1; ld2_res = $urandom; cnt++;
                ld2_res_tag = 5'(m_tag[r]);
            end
            tick();
            checks++;
            if (dut_vec() !== exp_vec() || stall_out !== (m_outst > 29)) begin
                errors++; $display("FAIL random_bundle cyc %0d got %h s%b want %h s%b",
                                   i, dut_vec(), stall_out, exp_vec(), m_outst > 29);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs(); valid1 = 1; rs1 = 1; rd1 = 14; wr1 = 1; tick();
        stall_in = 1; tick();
        checks++;
        if (out_valid1 !== 1'b1) begin errors++; $display("FAIL pre_reset_hold got %b want 1", out_valid1); end
        rst = 1;
        #1;
        checks++;
        if (dut_vec() !== 176'd0 || stall_out !== 1'b0) begin
            errors++; $display("FAIL reset_mid_stall got %h s%b want 0", dut_vec(), stall_out);
        end
        model_reset(); clear_inputs();
        @(posedge clk); #1;
        rst = 0;
        clear_inputs(); valid1 = 1; rs1 = 14; rd1 = 15; wr1 = 1;
        tick();
        checks++;
        if ({ready_rs1, val1_1, dest1_tag} !== {1'b1, 32'h0, 5'd0} || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL post_reset got r%b %h t%0d want r1 0 t0", ready_rs1, val1_1, dest1_tag);
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_intra_raw();
        test_cdb_bypass();
        test_waw();
        test_r0();
        test_stall_in_snoop();
        test_stall_out();
        test_random();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
